// File: rtl/irt_pkg.sv
// irt_pkg: shared width helpers, hazard types and bit-scan function for the dependency tracker
package irt_pkg;
  typedef enum logic [1:0] {RAW, WAR, WAW} hazard_e;
  function automatic int reg_addr_bits(input int regnum);
    return $clog2(regnum);
  endfunction
  function automatic int bs_bits(input int bs);
    return $clog2(bs);
  endfunction
  function automatic int lowest_set(input logic [63:0] v);
    lowest_set = 0;
    for (int i = 63; i >= 0; i--)
      if (v[i]) lowest_set = i;
  endfunction
endpackage

// File: rtl/irt_prio_enc.sv
// irt_prio_enc: lowest-numbered free slot finder with any-free flag
module irt_prio_enc
  import irt_pkg::*;
#(
  parameter int BS = 16,
  localparam int IW = bs_bits(BS)
) (
  input  logic [BS-1:0] free,
  output logic [IW-1:0] idx,
  output logic          any
);
  assign idx = IW'(lowest_set(64'(free)));
  assign any = |free;
endmodule

// File: rtl/irt_dep_tracker.sv
// irt_dep_tracker: issue-buffer slot allocator with RAW/WAR/WAW dependency matrix and ready vector
module irt_dep_tracker
  import irt_pkg::*;
#(
  parameter int REGNUM = 32,
  parameter int BS = 16,
  parameter int NSRC = 2,
  parameter bit TRACK_WAR = 1'b1,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW = reg_addr_bits(REGNUM),
  localparam int IW = bs_bits(BS),
  localparam int OW = $clog2(BS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  input  logic [NSRC*AW-1:0] alloc_rs,
  input  logic [NSRC-1:0]  alloc_rs_en,
  input  logic [AW-1:0]    alloc_rd,
  input  logic             alloc_rd_en,
  output logic [IW-1:0]    alloc_idx,
  output logic [BS-1:0]    alloc_dep,
  output logic             alloc_dep_valid,
  input  logic             issue_valid,
  input  logic [IW-1:0]    issue_idx,
  input  logic             retire_valid,
  input  logic [IW-1:0]    retire_idx,
  output logic [BS-1:0]    entry_rdy,
  output logic [OW-1:0]    occupancy,
  output logic             retire_err
);
  logic [BS-1:0] valid, issued, row, n_mask, r_mask, rt_mask, clr_mask;
  logic [BS-1:0] dep [BS];
  logic [BS-1:0] rs_tab [REGNUM];
  logic [BS-1:0] rd_tab [REGNUM];
  logic [REGNUM-1:0] rs_hit, rd_hit;
  logic any_free, acc, ret_ok, iss_ok, rd_use;

  irt_prio_enc #(.BS(BS)) u_enc (.free(~valid), .idx(alloc_idx), .any(any_free));

  assign alloc_ready = any_free;
  assign acc = alloc_valid & any_free;
  assign ret_ok = retire_valid & valid[retire_idx];
  assign iss_ok = issue_valid & entry_rdy[issue_idx];
  assign rd_use = alloc_rd_en & ~(ZERO_REG & (alloc_rd == '0));
  assign n_mask = BS'(1) << alloc_idx;
  // any retiring column is excluded from the new row, even though the slot is still valid this cycle
  assign r_mask = retire_valid ? BS'(1) << retire_idx : '0;
  assign rt_mask = ret_ok ? r_mask : '0;
  assign clr_mask = (acc ? n_mask : '0) | rt_mask;

  always_comb begin
    rs_hit = '0;
    rd_hit = '0;
    row = '0;
    for (int k = 0; k < NSRC; k++)
      if (alloc_rs_en[k] && !(ZERO_REG && alloc_rs[k*AW +: AW] == '0)) begin
        rs_hit[alloc_rs[k*AW +: AW]] = 1'b1;
        row = row | rd_tab[alloc_rs[k*AW +: AW]];
      end
    if (rd_use) begin
      rd_hit[alloc_rd] = 1'b1;
      row = row | rd_tab[alloc_rd] | (TRACK_WAR ? rs_tab[alloc_rd] : '0);
    end
    row = row & valid & ~n_mask & ~r_mask;
  end

  always_comb begin
    entry_rdy = '0;
    for (int i = 0; i < BS; i++) entry_rdy[i] = valid[i] & ~issued[i] & ~|dep[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      issued <= '0;
      occupancy <= '0;
      alloc_dep <= '0;
      alloc_dep_valid <= 1'b0;
      retire_err <= 1'b0;
      for (int i = 0; i < BS; i++) dep[i] <= '0;
      for (int r = 0; r < REGNUM; r++) begin
        rs_tab[r] <= '0;
        rd_tab[r] <= '0;
      end
    end else begin
      valid <= (valid | (acc ? n_mask : '0)) & ~rt_mask;
      issued <= (issued | (iss_ok ? BS'(1) << issue_idx : '0)) & ~clr_mask;
      occupancy <= occupancy + OW'(acc) - OW'(ret_ok);
      alloc_dep_valid <= acc;
      retire_err <= retire_valid & ~valid[retire_idx];
      if (acc) alloc_dep <= row;
      for (int i = 0; i < BS; i++)
        dep[i] <= (acc && i == int'(alloc_idx)) ? row : dep[i] & ~rt_mask;
      for (int r = 0; r < REGNUM; r++) begin
        rs_tab[r] <= (rs_tab[r] & ~clr_mask) | ((acc && rs_hit[r]) ? n_mask : '0);
        rd_tab[r] <= (rd_tab[r] & ~clr_mask) | ((acc && rd_hit[r]) ? n_mask : '0);
      end
    end
  end
endmodule

// File: doc/irt_dep_tracker.md
# irt_dep_tracker

Parametrised instruction dependency tracker for the out-of-order issue buffer. Accepts one decoded instruction per cycle and allocates it a buffer slot. Builds its RAW/WAR/WAW dependency row against all in-flight slots. Clears dependencies as slots retire and publishes a per-slot ready-to-issue vector to the scheduler. It sits between decode and issue select.

## Interface
- `REGNUM`, 32: architectural register count; address width is `$clog2(REGNUM)`.
- `BS`, 16: buffer slots; index width is `$clog2(BS)`.
- `NSRC`, 2: source operands per instruction (1..3).
- `TRACK_WAR`, 1: 1 tracks WAR hazards; 0 omits them (renamed back-end).
- `ZERO_REG`, 1: 1 means register 0 never creates or receives dependencies.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `alloc_valid` in 1: decode presents an instruction.
- `alloc_ready` out 1: at least one free slot exists.
- `alloc_rs` in NSRC×addr: source register addresses, packed with source 0 in the LSBs.
- `alloc_rs_en` in NSRC: per-source valid; a disabled source is ignored.
- `alloc_rd` in addr: destination register.
- `alloc_rd_en` in 1: instruction writes `alloc_rd`.
- `alloc_idx` out idx: slot that will be taken; combinational and meaningful only while `alloc_ready` is 1.
- `alloc_dep` out BS: dependency row of the last accepted instruction, registered.
- `alloc_dep_valid` out 1: one-cycle pulse accompanying `alloc_dep`.
- `issue_valid`, `issue_idx` in 1 / idx: scheduler marks a slot issued.
- `retire_valid`, `retire_idx` in 1 / idx: slot completes and is freed.
- `entry_rdy` out BS: slot is valid, not yet issued, and its dependency row is all zero.
- `occupancy` out `$clog2(BS+1)`: number of valid slots.
- `retire_err` out 1: one-cycle pulse when a retire targets an invalid slot.

## Operation
- State:
  - per-slot `valid` and `issued` bits;
  - dependency matrix `dep[BS][BS]`, where row i bit j means slot i waits on slot j;
  - register tables `rs_tab[REGNUM][BS]` and `rd_tab[REGNUM][BS]` recording which slots read or write each register.
- Accept condition: `alloc_valid & alloc_ready`. `alloc_idx` is the lowest-numbered slot with `valid=0`.
- Dependency row for the new slot n is formed from `rd_tab`/`rs_tab` state before the edge:
  - OR of `rd_tab[rs_k]` over the enabled sources (RAW);
  - `rs_tab[rd]` (WAR), only when `TRACK_WAR=1` and `alloc_rd_en=1`;
  - `rd_tab[rd]` (WAW), only when `alloc_rd_en=1`;
  - the result is masked by `valid`, by the `~(1<<n)` self bit, and by the column being retired this cycle.
- With `ZERO_REG=1`, any term whose address is 0 contributes nothing and is not written into the tables.
- On accept: first clear column n in both tables, then set `rs_tab[rs_k][n]` and `rd_tab[rd][n]`. Also set `valid[n]=1`, `issued[n]=0`, `dep[n]=row`, and register `row` onto `alloc_dep`.
- Issue: sets `issued[issue_idx]`. Issuing an invalid slot or a slot whose `entry_rdy` is 0 is ignored.
- Retire: clears `valid`, `issued`, column `retire_idx` of every `dep` row, and column `retire_idx` of both tables. A retire to an invalid slot changes no state and pulses `retire_err`.
- Simultaneous retire and alloc: the retire is applied first to the dependency masking. The freed slot is not offered to the allocator until the next cycle, because `alloc_ready` and `alloc_idx` derive from registered `valid`.
- Simultaneous issue and retire of the same slot: the retire wins.
- `occupancy` counts +1 on accept and −1 on a valid retire; both in the same cycle means no change. It never exceeds BS.

## Timing
- After `rst`:
  - `valid`, `issued`, `dep` and both tables are all 0;
  - `alloc_ready=1`, `alloc_idx=0`;
  - `alloc_dep=0`, `alloc_dep_valid=0`;
  - `entry_rdy=0`, `occupancy=0`, `retire_err=0`.
- `rst` asserted mid-operation discards every in-flight slot at that edge and overrides all same-cycle inputs.
- `alloc_dep` and `alloc_dep_valid` are valid one cycle after the accepting edge.
- `entry_rdy` for a new slot can rise one cycle after the accepting edge.
- A retire at edge t clears the dependent's bit; that dependent's `entry_rdy` can rise in the cycle after t.
- Full condition: when `occupancy=BS`, `alloc_ready=0`, and `alloc_valid` is ignored without stalling other operations.

## Structure
- Package `irt_pkg`:
  - width helpers (`reg_addr_bits`, `bs_bits`);
  - hazard-type enum `{RAW, WAR, WAW}`, used by the debug/assert layer;
  - lowest-set-bit function.
- Sub-module `irt_prio_enc`: a BS-wide lowest-free-slot finder producing `alloc_idx` and an any-free flag.

## Test plan
- Reset, then alloc `rs=(1,2)`, `rd=3` → `alloc_idx=0`; next cycle `alloc_dep=0` and `entry_rdy=16'h0001`.
- Slot 0 writes r3, then alloc `rs=(3,0)`, `rd=4` → slot 1 `alloc_dep=16'h0001`; retire slot 0 → `entry_rdy[1]` rises the following cycle.
- WAR with `TRACK_WAR=1`: slot 0 reads r5, slot 1 writes r5 → `alloc_dep=16'h0001`; repeat with `TRACK_WAR=0` → `alloc_dep=0`.
- Fill all 16 slots → `alloc_ready=0` and `occupancy=16`. Retire slot 7 with `alloc_valid` held → no accept that cycle; next cycle `alloc_idx=7` and the alloc is accepted.
- Alloc reading r3 in the same cycle that slot 0 (writer of r3) retires → `alloc_dep` bit 0 is 0.
- Retire an invalid slot 9 → `retire_err` pulses for one cycle and `occupancy` is unchanged; `rd=0` with `ZERO_REG=1` creates no WAW dependency.
